// File: rtl/counter_multimode.sv
// Multi-mode up/down counter with modulo terminal, prescaler, load, wrap/saturate,
// terminal-count pulse and sticky overflow flag.
module counter_multimode #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] MOD_MAX   = {WIDTH{1'b1}},
    parameter int               PRESCALE  = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] last,
    output logic             tc,
    output logic             ovf
);

    localparam int               PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]    PS_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0]    PS_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [PW-1:0]    presc_r;
    logic [PW-1:0]    presc_nxt_s;
    logic             step_s;
    logic             at_term_s;
    logic             term_s;
    logic [WIDTH-1:0] last_nxt_s;

    // Loaded values above the terminal are pulled back into the legal range.
    function automatic logic [WIDTH-1:0] clip_to_mod(input logic [WIDTH-1:0] v);
        return (v > MOD_MAX) ? MOD_MAX : v;
    endfunction

    // Prescaler advance, step qualification and next count value.
    always_comb begin
        presc_nxt_s = presc_r;
        step_s      = en && (presc_r == PS_LAST);
        at_term_s   = dir ? (last == ZERO) : (last == MOD_MAX);
        term_s      = step_s && at_term_s;
        last_nxt_s  = last;
        if (en) begin
            presc_nxt_s = (presc_r == PS_LAST) ? PS_ZERO : (presc_r + PS_ONE);
        end else begin
            presc_nxt_s = presc_r;
        end
        if (!step_s) begin
            last_nxt_s = last;
        end else if (at_term_s) begin
            // Never overflow into 2**WIDTH space: wrap explicitly to the modulo bounds.
            last_nxt_s = sat ? last : (dir ? MOD_MAX : ZERO);
        end else if (dir) begin
            last_nxt_s = last - ONE;
        end else begin
            last_nxt_s = last + ONE;
        end
    end

    // State and output registers: reset > load > step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last    <= RESET_VAL;
            presc_r <= PS_ZERO;
            tc      <= 1'b0;
            ovf     <= 1'b0;
        end else if (load) begin
            last    <= clip_to_mod(load_val);
            presc_r <= PS_ZERO;
            tc      <= 1'b0;
            ovf     <= ovf & ~ovf_clr;
        end else begin
            last    <= last_nxt_s;
            presc_r <= presc_nxt_s;
            tc      <= term_s;
            ovf     <= term_s | (ovf & ~ovf_clr);
        end
    end

endmodule

// File: tb/tb_counter_multimode.sv
// Randomized and directed bench for counter_multimode against an arithmetic reference model
// on three configurations (mod-10, mod-10 with prescale 3, default 32-bit).
module tb_counter_multimode;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0, dir = 1'b0, sat = 1'b0, load = 1'b0, ovf_clr = 1'b0;
    logic [3:0]  lv4 = 4'd0;
    logic [31:0] lv32 = 32'd0;
    logic [3:0]  last_a, last_b;
    logic [31:0] last_c;
    logic        tc_a, tc_b, tc_c, ovf_a, ovf_b, ovf_c;

    int errors = 0;
    int checks = 0;

    typedef struct {
        longint cnt;
        int     ph;
        bit     tc;
        bit     ovf;
    } model_t;

    model_t ma, mb, mc;

    localparam longint MAX_C = 64'h0000_0000_FFFF_FFFF;

    always #5 clk = ~clk;

    counter_multimode #(.WIDTH(4), .MOD_MAX(4'd9), .PRESCALE(1), .RESET_VAL(4'd0)) dut_a (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .sat(sat), .load(load),
        .load_val(lv4), .ovf_clr(ovf_clr), .last(last_a), .tc(tc_a), .ovf(ovf_a));

    counter_multimode #(.WIDTH(4), .MOD_MAX(4'd9), .PRESCALE(3), .RESET_VAL(4'd2)) dut_b (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .sat(sat), .load(load),
        .load_val(lv4), .ovf_clr(ovf_clr), .last(last_b), .tc(tc_b), .ovf(ovf_b));

    counter_multimode dut_c (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .sat(sat), .load(load),
        .load_val(lv32), .ovf_clr(ovf_clr), .last(last_c), .tc(tc_c), .ovf(ovf_c));

    task automatic check_val(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic model_t model_reset(input longint rv);
        model_t m;
        m.cnt = rv; m.ph = 0; m.tc = 1'b0; m.ovf = 1'b0;
        return m;
    endfunction

    // Reference behaviour: count is an integer in 0..modmax, stepping every presc enabled cycles.
    function automatic model_t model_next(input model_t m, input bit e, input bit d, input bit s,
                                          input bit l, input longint v, input bit c,
                                          input longint modmax, input int presc);
        model_t n = m;
        bit     step, term;
        if (l) begin
            n.cnt = (v > modmax) ? modmax : v;
            n.ph  = 0;
            n.tc  = 1'b0;
            n.ovf = m.ovf && !c;
        end else begin
            step = e && (m.ph == presc - 1);
            if (e) n.ph = (m.ph + 1) % presc;
            term = step && (d ? (m.cnt == 0) : (m.cnt == modmax));
            if (step && !(term && s))
                n.cnt = d ? (m.cnt + modmax) % (modmax + 1) : (m.cnt + 1) % (modmax + 1);
            n.tc  = term;
            n.ovf = term || (m.ovf && !c);
        end
        return n;
    endfunction

    task automatic check_all(input string ph);
        check_val({ph, "_a_last"}, last_a, ma.cnt);
        check_val({ph, "_a_tc"},   tc_a,   ma.tc);
        check_val({ph, "_a_ovf"},  ovf_a,  ma.ovf);
        check_val({ph, "_b_last"}, last_b, mb.cnt);
        check_val({ph, "_b_tc"},   tc_b,   mb.tc);
        check_val({ph, "_b_ovf"},  ovf_b,  mb.ovf);
        check_val({ph, "_c_last"}, last_c, mc.cnt);
        check_val({ph, "_c_tc"},   tc_c,   mc.tc);
        check_val({ph, "_c_ovf"},  ovf_c,  mc.ovf);
    endtask

    // Called just after a rising edge: drive inputs, take one edge, advance models, compare.
    task automatic do_cycle(input bit e, input bit d, input bit s, input bit l,
                            input logic [3:0] v4, input logic [31:0] v32, input bit c,
                            input string ph);
        en = e; dir = d; sat = s; load = l; lv4 = v4; lv32 = v32; ovf_clr = c;
        @(posedge clk);
        ma = model_next(ma, e, d, s, l, longint'(v4), c, 9, 1);
        mb = model_next(mb, e, d, s, l, longint'(v4), c, 9, 3);
        mc = model_next(mc, e, d, s, l, longint'(v32), c, MAX_C, 1);
        #1;
        check_all(ph);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        check_val("rst_a_last", last_a, 0);
        check_val("rst_b_last", last_b, 2);
        check_val("rst_c_last", last_c, 0);
        check_val("rst_tc",  {tc_a, tc_b, tc_c}, 0);
        check_val("rst_ovf", {ovf_a, ovf_b, ovf_c}, 0);
        #1 reset = 1'b0;
        ma = model_reset(0); mb = model_reset(2); mc = model_reset(0);
    endtask

    initial begin
        ma = model_reset(0); mb = model_reset(2); mc = model_reset(0);
        #12;
        check_all("reset");
        #1 reset = 1'b0;

        // Wrap-up count through the mod-10 terminal
        for (int i = 1; i <= 12; i++) begin
            do_cycle(1, 0, 0, 0, 4'd0, 32'd0, 0, "t1");
            check_val("t1_last", last_a, i % 10);
            check_val("t1_tc", tc_a, (i == 10) ? 1 : 0);
        end
        check_val("t1_ovf", ovf_a, 1);

        // Count down through zero with a coincident overflow clear
        do_cycle(0, 1, 0, 1, 4'd0, 32'd0, 0, "t2");
        do_cycle(1, 1, 0, 0, 4'd0, 32'd0, 1, "t2");
        check_val("t2_wrap_last", last_a, 9);
        check_val("t2_wrap_tc", tc_a, 1);
        check_val("t2_set_wins", ovf_a, 1);
        do_cycle(1, 1, 0, 0, 4'd0, 32'd0, 1, "t2");
        check_val("t2_next_last", last_a, 8);
        check_val("t2_clr", ovf_a, 0);

        // Saturate at the top, then reverse
        do_cycle(1, 0, 1, 1, 4'd8, 32'd0, 0, "t3");
        check_val("t3_load", last_a, 8);
        for (int i = 0; i < 4; i++) begin
            do_cycle(1, 0, 1, 0, 4'd0, 32'd0, 0, "t3");
            check_val("t3_sat_last", last_a, 9);
            check_val("t3_sat_tc", tc_a, (i == 0) ? 0 : 1);
        end
        do_cycle(1, 1, 1, 0, 4'd0, 32'd0, 0, "t3");
        check_val("t3_rev", last_a, 8);

        // Out-of-range load clips; load restarts the prescaler
        do_cycle(1, 0, 0, 1, 4'd15, 32'd0, 0, "t4");
        check_val("t4_clip_a", last_a, 9);
        check_val("t4_clip_b", last_b, 9);
        for (int i = 1; i <= 3; i++) begin
            do_cycle(1, 0, 0, 0, 4'd0, 32'd0, 0, "t4");
            check_val("t4_presc_b", last_b, (i == 3) ? 0 : 9);
        end
        check_val("t4_presc_tc", tc_b, 1);

        // Enable gap in the middle of a prescale period keeps the phase
        do_cycle(0, 0, 0, 1, 4'd4, 32'd0, 0, "t5");
        do_cycle(1, 0, 0, 0, 4'd0, 32'd0, 0, "t5");
        do_cycle(0, 0, 0, 0, 4'd0, 32'd0, 0, "t5");
        do_cycle(0, 0, 0, 0, 4'd0, 32'd0, 0, "t5");
        do_cycle(1, 0, 0, 0, 4'd0, 32'd0, 0, "t5");
        check_val("t5_hold", last_b, 4);
        do_cycle(1, 0, 0, 0, 4'd0, 32'd0, 0, "t5");
        check_val("t5_step", last_b, 5);

        // Reset between edges mid-count, then 32-bit wrap
        do_cycle(0, 0, 0, 1, 4'd5, 32'hFFFF_FFFF, 0, "t6");
        check_val("t6_pre_a", last_a, 5);
        async_reset();
        do_cycle(0, 0, 0, 1, 4'd5, 32'hFFFF_FFFF, 0, "t6");
        do_cycle(1, 0, 0, 0, 4'd0, 32'd0, 0, "t6");
        check_val("t6_wrap32", last_c, 0);
        check_val("t6_wrap32_tc", tc_c, 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] v32;
            case ($urandom_range(0, 3))
                0:       v32 = 32'hFFFF_FFFF;
                1:       v32 = 32'hFFFF_FFFE;
                2:       v32 = 32'd1;
                default: v32 = $urandom;
            endcase
            if ($urandom_range(0, 99) == 0) async_reset();
            do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                     4'($urandom_range(0, 15)), v32, $urandom_range(0, 7) == 0, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
